// File: rtl/bridge_arbiter.sv
// bridge_arbiter: two-master round-robin arbiter and access sequencer for the
// bridge's processor-side bus. One access is in flight at a time; it is held
// until dev_ready or until the timeout counter expires.
module bridge_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic [3:0]  m0_be,
  input  logic        m0_we,
  output logic        m0_ack,
  output logic [31:0] m0_rd,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic [3:0]  m1_be,
  input  logic        m1_we,
  output logic        m1_ack,
  output logic [31:0] m1_rd,
  output logic        m1_err,
  output logic [31:0] PrAddr,
  output logic [31:0] PrWD,
  output logic [3:0]  PrBE,
  output logic        PrWe,
  input  logic [31:0] PrRD,
  input  logic        dev_ready,
  output logic        busy,
  output logic [1:0]  grant
);

  localparam int unsigned   CW           = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST     = CW'(TIMEOUT - 1);
  localparam logic [31:0]   TIMEOUT_DATA = 32'h16231138;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          last_grant;  // 1 = master 1 owned the previous access
  logic          owner;       // 1 = master 1 owns the current access
  logic          we_q;
  logic [CW-1:0] cnt;
  logic [31:0]   rd_q;
  logic          err_q;
  logic          any_req;
  logic          pick_m1;
  logic          cnt_expired;

  // Round-robin choice: a lone requester wins; on a tie the master that did not go last wins.
  always_comb begin
    any_req     = m0_req | m1_req;
    pick_m1     = m1_req & (~m0_req | ~last_grant);
    cnt_expired = (cnt == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; dev_ready takes priority over an expiring timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (dev_ready || cnt_expired) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Access payload latch, arbitration history, wait counter and response capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      cnt        <= '0;
      PrAddr     <= '0;
      PrWD       <= '0;
      PrBE       <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= pick_m1;
            last_grant <= pick_m1;
            PrAddr     <= pick_m1 ? m1_addr : m0_addr;
            PrWD       <= pick_m1 ? m1_wd   : m0_wd;
            PrBE       <= pick_m1 ? m1_be   : m0_be;
            we_q       <= pick_m1 ? m1_we   : m0_we;
            cnt        <= '0;
          end
        end
        ACCESS: begin
          if (dev_ready) begin
            rd_q  <= PrRD;
            err_q <= 1'b0;
          end else if (cnt_expired) begin
            rd_q  <= TIMEOUT_DATA;
            err_q <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; PrWe is combinational so an async reset drops it at once.
  always_comb begin
    PrWe   = 1'b0;
    busy   = 1'b0;
    grant  = '0;
    m0_ack = 1'b0;
    m0_rd  = '0;
    m0_err = 1'b0;
    m1_ack = 1'b0;
    m1_rd  = '0;
    m1_err = 1'b0;
    case (state)
      ACCESS: begin
        busy  = 1'b1;
        PrWe  = we_q;
        grant = owner ? 2'b10 : 2'b01;
      end
      DONE: begin
        busy = 1'b1;
        if (owner) begin
          m1_ack = 1'b1;
          m1_rd  = rd_q;
          m1_err = err_q;
        end else begin
          m0_ack = 1'b1;
          m0_rd  = rd_q;
          m0_err = err_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Testbench for bridge_arbiter: directed scenarios followed by randomized
// traffic, checked against a transaction-level latency/arbitration model.
module tb_bridge_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_m  [2];
  logic [31:0] addr_m [2];
  logic [31:0] wd_m   [2];
  logic [3:0]  be_m   [2];
  logic        we_m   [2];
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rd, m1_rd;
  logic [31:0] PrAddr, PrWD, PrRD;
  logic [3:0]  PrBE;
  logic        PrWe, dev_ready, busy;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_err    = 0;
  bit pend [2];
  int last_g = 1;

  bridge_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(req_m[0]), .m0_addr(addr_m[0]), .m0_wd(wd_m[0]), .m0_be(be_m[0]), .m0_we(we_m[0]),
    .m0_ack(m0_ack), .m0_rd(m0_rd), .m0_err(m0_err),
    .m1_req(req_m[1]), .m1_addr(addr_m[1]), .m1_wd(wd_m[1]), .m1_be(be_m[1]), .m1_we(we_m[1]),
    .m1_ack(m1_ack), .m1_rd(m1_rd), .m1_err(m1_err),
    .PrAddr(PrAddr), .PrWD(PrWD), .PrBE(PrBE), .PrWe(PrWe), .PrRD(PrRD),
    .dev_ready(dev_ready), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic w);
    pend[m]   = 1'b1;
    req_m[m]  = 1'b1;
    addr_m[m] = a;
    wd_m[m]   = d;
    be_m[m]   = b;
    we_m[m]   = w;
  endtask

  task automatic check_idle();
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, 0);
    chk("idle_prwe", PrWe, 0);
    chk("idle_ack0", m0_ack, 0);
    chk("idle_ack1", m1_ack, 0);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_m[0]  = 1'b0;
    req_m[1]  = 1'b0;
    pend[0]   = 1'b0;
    pend[1]   = 1'b0;
    dev_ready = 1'b0;
    #1;
    chk("rst_praddr", PrAddr, 0);
    chk("rst_prwd", PrWD, 0);
    chk("rst_prbe", PrBE, 0);
    chk("rst_prwe", PrWe, 0);
    chk("rst_ack0", m0_ack, 0);
    chk("rst_ack1", m1_ack, 0);
    chk("rst_rd0", m0_rd, 0);
    chk("rst_rd1", m1_rd, 0);
    chk("rst_err0", m0_err, 0);
    chk("rst_err1", m1_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    step();
    reset_n = 1'b1;
    last_g  = 1;
  endtask

  // Called in an IDLE cycle with the pending requests already driven.
  // w0/w1: not-ready cycles before dev_ready for each master (>= TO means never).
  task automatic serve(input int w0, input int w1, input bit drop,
                       input bit fix_rd, input logic [31:0] rdfix);
    int          win;
    int          w;
    logic [31:0] sa, swd, v, exp_rd;
    logic [3:0]  sbe;
    logic        swe, exp_err;
    if (pend[0] && pend[1]) win = (last_g == 1) ? 0 : 1;
    else                    win = pend[0] ? 0 : 1;
    last_g  = win;
    w       = (win == 1) ? w1 : w0;
    sa      = addr_m[win];
    swd     = wd_m[win];
    sbe     = be_m[win];
    swe     = we_m[win];
    exp_rd  = '0;
    exp_err = 1'b0;
    step();
    for (int c = 1; c <= int'(TO); c++) begin
      chk("acc_busy", busy, 1);
      chk("acc_grant", grant, (win == 1) ? 2'b10 : 2'b01);
      chk("acc_praddr", PrAddr, sa);
      chk("acc_prwd", PrWD, swd);
      chk("acc_prbe", PrBE, sbe);
      chk("acc_prwe", PrWe, swe);
      chk("acc_ack0", m0_ack, 0);
      chk("acc_ack1", m1_ack, 0);
      v         = fix_rd ? rdfix : $urandom;
      PrRD      = v;
      dev_ready = (c == w + 1);
      if (c == w + 1) begin
        exp_rd  = v;
        exp_err = 1'b0;
      end else if (c == int'(TO)) begin
        exp_rd  = 32'h16231138;
        exp_err = 1'b1;
      end
      if (drop && c == 1) begin
        req_m[win]  = 1'b0;
        addr_m[win] = $urandom;
        wd_m[win]   = $urandom;
        we_m[win]   = ~swe;
      end
      step();
      if (c == w + 1 || c == int'(TO)) break;
    end
    dev_ready = 1'($urandom);
    PrRD      = $urandom;
    chk("done_busy", busy, 1);
    chk("done_grant", grant, 0);
    chk("done_prwe", PrWe, 0);
    chk("done_ack0", m0_ack, (win == 0) ? 1 : 0);
    chk("done_ack1", m1_ack, (win == 1) ? 1 : 0);
    chk("done_rd0", m0_rd, (win == 0) ? exp_rd : 0);
    chk("done_rd1", m1_rd, (win == 1) ? exp_rd : 0);
    chk("done_err0", m0_err, (win == 0) ? exp_err : 0);
    chk("done_err1", m1_err, (win == 1) ? exp_err : 0);
    req_m[win] = 1'b0;
    pend[win]  = 1'b0;
    dev_ready  = 1'b0;
    step();
    check_idle();
    chk("hold_praddr", PrAddr, sa);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      req_m[m]  = 1'b0;
      addr_m[m] = '0;
      wd_m[m]   = '0;
      be_m[m]   = '0;
      we_m[m]   = 1'b0;
    end
    PrRD = '0;
    do_reset();

    // m0 zero-wait read
    new_req(0, 32'h00007f34, 32'h0, 4'hF, 1'b0);
    serve(0, 0, 1'b0, 1'b1, 32'h000000A5);

    // m1 write with three wait cycles
    new_req(1, 32'h00007f00, 32'h00000009, 4'b1111, 1'b1);
    serve(0, 3, 1'b0, 1'b0, 32'h0);

    // both masters requesting continuously from reset
    do_reset();
    new_req(0, 32'h100, 32'h11, 4'h3, 1'b0);
    new_req(1, 32'h200, 32'h22, 4'hC, 1'b1);
    for (int i = 0; i < 4; i++) begin
      serve(0, 0, 1'b0, 1'b0, 32'h0);
      new_req(last_g, $urandom, $urandom, 4'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 2; i++) serve(0, 0, 1'b0, 1'b0, 32'h0);

    // timeout on a read
    new_req(0, 32'h00000040, 32'h0, 4'hF, 1'b0);
    serve(100, 0, 1'b0, 1'b0, 32'h0);

    // ready on the last allowed cycle beats the timeout
    new_req(0, 32'h00000044, 32'h0, 4'hF, 1'b0);
    serve(int'(TO) - 1, 0, 1'b0, 1'b1, 32'h00001234);

    // reset in the middle of a stuck write
    new_req(0, 32'h00000080, 32'hDEADBEEF, 4'hF, 1'b1);
    dev_ready = 1'b0;
    step();
    chk("rstmid_prwe_before", PrWe, 1);
    step();
    chk("rstmid_busy_before", busy, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rstmid_prwe", PrWe, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_grant", grant, 0);
    req_m[0] = 1'b0;
    pend[0]  = 1'b0;
    step();
    chk("rstmid_ack0", m0_ack, 0);
    chk("rstmid_ack1", m1_ack, 0);
    reset_n = 1'b1;
    last_g  = 1;
    new_req(1, 32'h000000C0, 32'h5, 4'h1, 1'b0);
    serve(0, 2, 1'b0, 1'b0, 32'h0);

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) != 0)
          new_req(m, $urandom, $urandom, 4'($urandom), 1'($urandom));
      end
      if (!pend[0] && !pend[1]) begin
        dev_ready = 1'($urandom);
        step();
        check_idle();
      end else begin
        serve($urandom_range(0, TO + 1), $urandom_range(0, TO + 1),
              $urandom_range(0, 3) == 0, 1'b0, 32'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/bridge_arbiter.md
# bridge_arbiter

Two-master arbiter and access sequencer in front of the system bridge's processor-side bus (PrAddr/PrWD/PrBE/PrWe/PrRD). It shares the bridge between the CPU M-stage (master 0) and a secondary master such as DMA or debug (master 1). Arbitration is round-robin. Each granted access is held stable until the addressed device signals ready. A timeout counter terminates accesses to a device that never responds, returning the debug constant 32'h16231138 with an error flag.

## Interface
- TIMEOUT, 255: maximum consecutive ACCESS cycles without dev_ready before the access is aborted; must be ≥1.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  access request; master holds it with stable payload until its ack.
- m0_addr, m1_addr  in  32  byte address.
- m0_wd, m1_wd  in  32  write data.
- m0_be, m1_be  in  4  byte enables.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rd, m1_rd  out  32  read data; valid while the matching ack=1.
- m0_err, m1_err  out  1  timeout flag; valid while the matching ack=1.
- PrAddr  out  32  to bridge.
- PrWD  out  32  to bridge.
- PrBE  out  4  to bridge.
- PrWe  out  1  to bridge.
- PrRD  in  32  read data from bridge.
- dev_ready  in  1  addressed device completes the access this cycle; devices commit writes only when PrWe=1 and dev_ready=1.
- busy  out  1  state ≠ IDLE.
- grant  out  2  one-hot owner of the current access; 00 when IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, select the winner, latch its addr/wd/be/we into the Pr* registers, set grant, clear the timeout counter, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration: last_grant register (reset = master 1).
  - Only one req high: that master wins.
  - Both high: the master that is not last_grant wins.
  - last_grant updates on each IDLE→ACCESS transition.
- ACCESS:
  - Pr* are driven from the latched registers; PrWe = latched we.
  - If dev_ready=1: capture PrRD into the rd register, clear err, and go to DONE.
  - Else if counter == TIMEOUT−1: load rd = 32'h16231138, set err=1, and go to DONE.
  - Else increment the counter.
  - dev_ready wins if it is asserted on the same cycle the timeout would fire.
- DONE:
  - Assert ack for the granted master only; m*_rd and m*_err show the registered values.
  - PrWe=0, grant cleared, then go to IDLE unconditionally.
  - The one-cycle bubble is mandatory, so a master never sees two acks in consecutive cycles.
- A request dropped during ACCESS is ignored: the access completes and ack still pulses.
- m*_rd and m*_err for the non-granted master are held at 0.
- Counter width: $clog2(TIMEOUT+1). It saturates and never wraps.
- PrWe is 0 in IDLE and DONE. Pr addr/data/be hold their last values outside ACCESS.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE; last_grant = master 1; counter = 0.
  - PrAddr, PrWD, PrBE, PrWe, m*_ack, m*_rd, m*_err, busy, grant all 0.
- Reset asserted mid-ACCESS drops PrWe within the same cycle. No ack is issued for the aborted access.
- Zero-wait-state access:
  - req sampled high at edge k.
  - ACCESS during cycle k..k+1, with Pr* valid.
  - dev_ready=1 sampled at edge k+1.
  - DONE (ack) during cycle k+1..k+2.
  - Back in IDLE after edge k+2.
  - Request-to-ack latency is 2 cycles; minimum issue interval is 3 cycles per access.
- N wait cycles (dev_ready low for N ACCESS cycles, N < TIMEOUT): ack is N cycles later than the zero-wait case.
- Timeout: ack+err appear TIMEOUT+1 cycles after the request is sampled.
- Both masters continuously requesting: grants alternate 0,1,0,1…, and each ack is 3 cycles apart.

## Test plan
- Reset release, m0 read of 32'h00007f34, dev_ready=1, PrRD=32'h000000A5 → PrAddr=7f34 and PrWe=0 in ACCESS; m0_ack=1 with m0_rd=32'hA5 and m0_err=0 exactly 2 cycles after req.
- m1 write addr 32'h00007f00, wd 32'h0000_0009, be 4'b1111, dev_ready low for 3 cycles then high → PrWe=1 for 4 ACCESS cycles; m1_ack 5 cycles after req; m0_ack stays 0.
- m0_req and m1_req both high from reset, held continuously → first grant=01 (m0), then 10, 01, 10; acks alternate at 3-cycle spacing.
- TIMEOUT=4, m0 read with dev_ready stuck 0 → m0_ack=1, m0_err=1, m0_rd=32'h16231138 after 5 cycles; then IDLE, busy=0.
- TIMEOUT=4, dev_ready rises on the 4th ACCESS cycle with PrRD=32'h1234 → m0_rd=32'h1234 and m0_err=0 (ready beats timeout).
- reset_n pulsed low during a write stuck in ACCESS → PrWe and busy go 0 immediately without a clock edge; no ack; after release, a new m1 request is granted normally.
